// File: rtl/timer_counter_if.sv
// Bridge-facing port bundle of one memory-mapped timer: decoded address,
// full-word write strobe and data, combinational read data and level IRQ.
interface timer_counter_if #(parameter int WIDTH = 32);
  logic [31:0]      Addr;
  logic             WE;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Dout;
  logic             IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload expiry, IRQ = irq_flag & CTRL.IM.
//
// state | meaning
// IDLE  | waiting for CTRL.En
// LOAD  | COUNT <= PRESET
// CNT   | decrementing; expiry sets irq_flag
// INT   | one-shot clears En, auto-reload clears irq_flag
module timer_counter #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;
  logic             irq_set;
  logic             en;
  logic             auto_reload;
  logic             unused_addr;

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    irq_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = '0;
          irq_set = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) irq_flag_d = 1'b0;
        else             ctrl_d[0]  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (irq_set) irq_flag_d = 1'b1;

    // Software writes override the FSM's En clear, but never a fresh expiry.
    if (bus.WE) begin
      case (bus.Addr[3:2])
        2'b00: begin
          ctrl_d = bus.Din[3:0];
          if (!irq_set) irq_flag_d = 1'b0;
        end
        2'b01:   preset_d = bus.Din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (bus.Addr[3:2])
      2'b00:   bus.Dout = {{(WIDTH-4){1'b0}}, ctrl_q};
      2'b01:   bus.Dout = preset_q;
      2'b10:   bus.Dout = count_q;
      default: bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = irq_flag_q & ctrl_q[3];

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped 32-bit down-counter timer for the MIPS CPU's peripheral space.
- Sits directly downstream of the system bus bridge. It consumes the bridge's address, write data and per-timer write enable, and returns its read data to the bridge's read mux.
- Two instances are used: Timer0 at 0x0000_7F00–0x0000_7F0B and Timer1 at 0x0000_7F10–0x0000_7F1B.
- Raises an interrupt request to the CP0/interrupt logic when the count expires.

Parameters:
- WIDTH, 32, width of the PRESET and COUNT registers and of the data path. Only 32 is verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  32  byte address from the bridge; only Addr[3:2] is decoded.
- WE  input  1  write enable from the bridge; asserted only for full-word stores that hit this timer.
- Din  input  32  write data from the bridge.
- Dout  output  32  read data, combinational from Addr[3:2] and the registers.
- IRQ  output  1  interrupt request, level.

Behaviour:
- Register map (Addr[3:2]):
  - 00 = CTRL: bits [3:0] writable; bits [31:4] read 0.
  - 01 = PRESET: read/write.
  - 10 = COUNT: read-only; writes ignored.
  - 11: reads 0; writes ignored.
- CTRL fields:
  - [0] En: count enable.
  - [2:1] Mode: 00 = one-shot; 01 = auto-reload; 1x behaves as 00.
  - [3] IM: interrupt mask, 1 = IRQ enabled.
- Reset (synchronous): CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0. Consequently IRQ = 0, and Dout = 0 for every address.
- Writes:
  - When WE = 1, the addressed register updates at the clock edge.
  - Dout has zero latency: the read is valid in the same cycle as Addr, so the bridge muxes it combinationally.
- FSM (states IDLE, LOAD, CNT, INT). The FSM acts on the registered CTRL value.
  - IDLE: if En = 1, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If En = 0: go to IDLE; COUNT holds its value.
    - Else if COUNT > 1: COUNT <= COUNT - 1.
    - Else (COUNT is 1 or 0): COUNT <= 0; irq_flag <= 1; go to INT.
  - INT:
    - One-shot mode: CTRL.En <= 0.
    - Auto-reload mode: irq_flag <= 0.
    - In both modes, go to IDLE.
- IRQ = irq_flag & CTRL.IM. Both terms are registered, so IRQ is glitch-free.
- Period in auto-reload mode is PRESET + 3 cycles for PRESET ≥ 1. PRESET = 0 behaves as PRESET = 1, giving a 4-cycle period. IRQ is a 1-cycle pulse per period.
- In one-shot mode, irq_flag stays set until software writes CTRL (any value) or reset is asserted. COUNT stays at 0 after expiry.
- Simultaneous events:
  - CTRL write in the same cycle as INT clearing En: the software write wins.
  - CTRL write in the same cycle as irq_flag being set (CNT→INT): the set wins, so no interrupt is lost.
- PRESET written while counting takes effect only at the next LOAD. The current COUNT is unaffected.
- Clearing En while in CNT freezes COUNT and returns the FSM to IDLE. Setting En again restarts from LOAD, i.e. reloads PRESET (no resume).
- Reset asserted mid-count returns everything to the reset values on that edge, overriding any simultaneous write.
- COUNT never wraps below 0.

Test Plan:
- Reset, then read addresses 0x7F00, 0x7F04, 0x7F08, 0x7F0C -> Dout = 0 for all four; IRQ = 0.
- Write PRESET = 5, then CTRL = 0x9 at edge e0 -> COUNT reads 5 after e2 and 4, 3, 2, 1 after e3–e6; COUNT = 0 and IRQ = 1 after e7; CTRL reads 0x8 after e8; IRQ stays 1 until a CTRL write of 0x8, then 0 on the next cycle.
- Write PRESET = 3, then CTRL = 0xB (auto-reload, IM = 1) -> IRQ pulses high for exactly 1 cycle every 6 cycles, for at least 4 periods; CTRL keeps reading 0xB.
- Repeat the auto-reload case with CTRL = 0x3 (IM = 0) -> IRQ stays 0 throughout while COUNT still cycles 3, 2, 1, 0.
- Write COUNT = 0x1234 while idle -> COUNT still reads 0. Write CTRL = 0xFFFF_FFFF -> CTRL reads 0xF.
- While counting from PRESET = 10 in one-shot mode:
  - Write CTRL = 0x8 at COUNT = 6 -> COUNT frozen at 6.
  - Then write PRESET = 2 and CTRL = 0x9 -> COUNT reloads to 2 and IRQ rises 2 cycles later.
  - Assert reset mid-count -> all registers read 0 and IRQ = 0 on the next cycle.
